// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: sequencing controller for the pipelined AES encryption datapath.
// Walks one block through round-0 load, rounds 1..Nr and a held done handshake.
// Optional feature macro: AES256_SUPPORT_EN (adds the captured key-size bit and
// a 14-round schedule; without it every block runs the AES-128 schedule).
//
// state | meaning
// IDLE  | waiting for start, ready=1
// LOAD  | round 0: plaintext XOR key, first key-gen step
// ROUND | rounds 1..Nr, last_round at Nr
// DONE  | result valid, held until out_ready
module aes_round_scheduler #(
  parameter int ROUNDS_128 = 10,
  parameter int ROUNDS_256 = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_size,
  input  logic       abort,
  input  logic       out_ready,
  output logic       ready,
  output logic       busy,
  output logic       load_en,
  output logic       key_gene_en,
  output logic [3:0] round_count,
  output logic       mix_en,
  output logic       last_round,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [3:0] w_nr;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef AES256_SUPPORT_EN
  logic r_size;

  // Key size is latched only on the accept edge; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_size <= 1'b0;
    else if (w_accept) r_size <= key_size;
  end

  assign w_nr = r_size ? 4'(ROUNDS_256) : 4'(ROUNDS_128);
`else
  logic w_unused_key_size;
  assign w_unused_key_size = key_size;
  assign w_nr = 4'(ROUNDS_128);
`endif

  // State and round counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Next-state and next-round decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_round_nxt = 4'd0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_ROUND;
        w_round_nxt = 4'd1;
      end
      S_ROUND: begin
        if (r_round == w_nr) begin
          w_state_nxt = S_DONE;
        end else if (r_round < w_nr) begin
          w_round_nxt = r_round + 4'd1;
        end else begin
          // Counter beyond Nr cannot happen in normal operation; recover.
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = 4'd0;
    end
  end

  // Outputs are pure decodes of state and round counter.
  assign ready       = (r_state == S_IDLE);
  assign busy        = (r_state == S_LOAD) || (r_state == S_ROUND);
  assign load_en     = (r_state == S_LOAD);
  assign mix_en      = (r_state == S_ROUND) && (r_round != w_nr);
  assign key_gene_en = load_en || mix_en;
  assign last_round  = (r_state == S_ROUND) && (r_round == w_nr);
  assign done        = (r_state == S_DONE);
  assign round_count = r_round;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench for aes_round_scheduler. A timeline model (cycles since
// accept) predicts every output each cycle; directed scenarios add literal
// expectations for cycle positions and strobe counts.
module tb_aes_round_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       key_size = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic       ready, busy, load_en, key_gene_en, mix_en, last_round, done;
  logic [3:0] round_count;

  int checks = 0;
  int errors = 0;

  aes_round_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .key_size(key_size), .abort(abort),
    .out_ready(out_ready), .ready(ready), .busy(busy), .load_en(load_en),
    .key_gene_en(key_gene_en), .round_count(round_count), .mix_en(mix_en),
    .last_round(last_round), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nr_for(input logic ks);
`ifdef AES256_SUPPORT_EN
    return ks ? 14 : 10;
`else
    return 10;
`endif
  endfunction

  // Model: m_t counts cycles since accept (1 = load, 1+r = round r, Nr+2 = done).
  bit m_active = 1'b0;
  int m_t = 0;
  int m_nr = 10;

  always @(posedge clk or posedge rst) begin
    if (rst) m_active = 1'b0;
    else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t = 1;
        m_nr = nr_for(key_size);
      end
    end else if (abort) m_active = 1'b0;
    else if (m_t >= m_nr + 2) begin
      if (out_ready) m_active = 1'b0;
    end else m_t++;
  end

  always @(negedge clk) begin
    int exp_rc;
    if (!m_active)            exp_rc = 0;
    else if (m_t == 1)        exp_rc = 0;
    else if (m_t <= m_nr + 1) exp_rc = m_t - 1;
    else                      exp_rc = m_nr;
    check("ready",       ready,       !m_active);
    check("busy",        busy,        m_active && m_t <= m_nr + 1);
    check("load_en",     load_en,     m_active && m_t == 1);
    check("key_gene_en", key_gene_en, m_active && m_t <= m_nr);
    check("mix_en",      mix_en,      m_active && m_t >= 2 && m_t <= m_nr);
    check("last_round",  last_round,  m_active && m_t == m_nr + 1);
    check("done",        done,        m_active && m_t >= m_nr + 2);
    check("round_count", round_count, exp_rc);
  end

  // One block: accept at the edge ending cycle 0; positions measured in cycles.
  task automatic run_block(input logic ks, input int hold,
                           output int c_load, output int c_last, output int c_done,
                           output int n_kge, output int n_done, output int c_ready);
    c_load = 0; c_last = 0; c_done = 0; n_kge = 0; n_done = 0; c_ready = 0;
    @(negedge clk);
    start = 1'b1;
    key_size = ks;
    out_ready = (hold == 0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c_done > 0) && (hold > 0) && (c == c_done + 2);
      if (c == 3) key_size = ~ks;
      if (load_en && c_load == 0) c_load = c;
      if (last_round && c_last == 0) c_last = c;
      if (key_gene_en) n_kge++;
      if (done) begin
        n_done++;
        if (c_done == 0) c_done = c;
      end
      if (c_done > 0 && ready) begin
        c_ready = c;
        break;
      end
      if (c_done > 0 && hold > 0 && c == c_done + hold) out_ready = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int cl, ct, cd, nk, nd, cr;
    int n, loads, dones, load1, load2;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_round", round_count, 0);
    rst = 1'b0;

    // AES-128, out_ready held high.
    run_block(1'b0, 0, cl, ct, cd, nk, nd, cr);
    check("a128_load_cyc", cl, 1);
    check("a128_last_cyc", ct, 11);
    check("a128_done_cyc", cd, 12);
    check("a128_kge_cnt", nk, 10);
    check("a128_done_cnt", nd, 1);
    check("a128_ready_cyc", cr, 13);

    // key_size = 1.
    run_block(1'b1, 0, cl, ct, cd, nk, nd, cr);
    check("ks1_load_cyc", cl, 1);
`ifdef AES256_SUPPORT_EN
    check("a256_last_cyc", ct, 15);
    check("a256_done_cyc", cd, 16);
    check("a256_kge_cnt", nk, 14);
    check("a256_ready_cyc", cr, 17);
`else
    check("ks1_last_cyc", ct, 11);
    check("ks1_done_cyc", cd, 12);
    check("ks1_kge_cnt", nk, 10);
    check("ks1_ready_cyc", cr, 13);
`endif

    // out_ready low for 5 cycles after done, with a start pulse in the window.
    run_block(1'b0, 5, cl, ct, cd, nk, nd, cr);
    check("hold_done_cyc", cd, 12);
    check("hold_done_cnt", nd, 6);
    check("hold_ready_cyc", cr, 18);

    // Abort in cycle 6.
    @(negedge clk);
    start = 1'b1;
    key_size = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_rc_before", round_count, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_rc", round_count, 0);
    check("abort_busy", busy, 0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", n, 0);

    // Reset pulse between edges in cycle 4.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    check("arst_load", load_en, 0);
    check("arst_kge", key_gene_en, 0);
    check("arst_mix", mix_en, 0);
    check("arst_last", last_round, 0);
    check("arst_done", done, 0);
    check("arst_rc", round_count, 0);
    rst = 1'b0;
    run_block(1'b0, 0, cl, ct, cd, nk, nd, cr);
    check("post_rst_load_cyc", cl, 1);
    check("post_rst_done_cyc", cd, 12);
    check("post_rst_kge_cnt", nk, 10);

    // start held high: back-to-back AES-128 blocks.
    @(negedge clk);
    start = 1'b1;
    key_size = 1'b0;
    out_ready = 1'b1;
    loads = 0; dones = 0; load1 = 0; load2 = 0;
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      if (load_en) begin
        loads++;
        if (loads == 1) load1 = c;
        if (loads == 2) load2 = c;
      end
      if (done) dones++;
    end
    start = 1'b0;
    check("b2b_loads", loads, 3);
    check("b2b_dones", dones, 3);
    check("b2b_gap", load2 - load1, 13);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
